// File: rtl/reg_file.sv
// 32x32 general-purpose register file: two registered read ports and one write port,
// all gated by valid_opcode, with a synchronous active-low clear of every register.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_opcode,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [ADDR_W-1:0] addr3,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Reads sample the pre-edge contents, so a same-edge write to the read address
    // is seen only by a later read (no bypass).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the array must be cleared here because reset clears every register;
            // this is why the storage is built from flops rather than a RAM macro.
            mem  <= '{default: '0};
            out1 <= '0;
            out2 <= '0;
        end else if (valid_opcode) begin
            out1        <= mem[addr1];
            out2        <= mem[addr2];
            mem[addr3]  <= in;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed and random stimulus feeds a reference model;
// expected read data is queued and a separate monitor compares it against the DUT.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_opcode = 1'b0;
    logic [4:0]  addr1 = '0;
    logic [4:0]  addr2 = '0;
    logic [4:0]  addr3 = '0;
    logic [31:0] in = '0;
    logic [31:0] out1;
    logic [31:0] out2;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        string       tag;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t sb[$];

    // Reference state: register contents and the last value each read port presented.
    logic [31:0] ref_regs [32];
    logic [31:0] ref_o1 = '0;
    logic [31:0] ref_o2 = '0;

    reg_file dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_opcode (valid_opcode),
        .addr1        (addr1),
        .addr2        (addr2),
        .addr3        (addr3),
        .in           (in),
        .out1         (out1),
        .out2         (out2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs, apply the register file rules to the model and queue
    // the read data the DUT should show after the coming rising edge.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                        input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        rst_n        = r;
        valid_opcode = v;
        addr1        = a1;
        addr2        = a2;
        addr3        = a3;
        in           = d;
        if (!r) begin
            foreach (ref_regs[i]) ref_regs[i] = '0;
            ref_o1 = '0;
            ref_o2 = '0;
        end else if (v) begin
            ref_o1 = ref_regs[a1];
            ref_o2 = ref_regs[a2];
            ref_regs[a3] = d;
        end
        e.tag = tag;
        e.e1  = ref_o1;
        e.e2  = ref_o2;
        sb.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: every rising edge with an outstanding expectation is compared 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, ".out1"}, out1, e.e1);
                check({e.tag, ".out2"}, out2, e.e2);
            end
        end
    end

    initial begin
        logic [4:0] a1, a2, a3;
        int drain;
        foreach (ref_regs[i]) ref_regs[i] = '0;

        // Reset held for two edges while a write is requested: nothing may be written.
        step("reset0", 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hFFFF_FFFF);
        step("reset1", 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hFFFF_FFFF);
        step("post_reset_read", 1'b1, 1'b1, 5'd5, 5'd31, 5'd6, 32'h0000_0001);

        // Write register 0, then read it back while writing register 7.
        step("write_r0", 1'b1, 1'b1, 5'd1, 5'd2, 5'd0, 32'h1234_5678);
        step("read_r0", 1'b1, 1'b1, 5'd0, 5'd7, 5'd7, 32'hA5A5_A5A5);

        // Dual read of distinct and identical addresses.
        step("load_r3", 1'b1, 1'b1, 5'd7, 5'd0, 5'd3, 32'hA5A5_A5A5);
        step("load_r4", 1'b1, 1'b1, 5'd3, 5'd3, 5'd4, 32'h0000_BEEF);
        step("dual_read", 1'b1, 1'b1, 5'd3, 5'd4, 5'd8, 32'h0000_0008);
        step("same_addr", 1'b1, 1'b1, 5'd3, 5'd3, 5'd9, 32'h0000_0009);

        // Read/write collision returns the old value; the new one appears on the next read.
        step("load_r10", 1'b1, 1'b1, 5'd0, 5'd0, 5'd10, 32'h1111_1111);
        step("collision", 1'b1, 1'b1, 5'd10, 5'd10, 5'd10, 32'h2222_2222);
        step("after_collision", 1'b1, 1'b1, 5'd10, 5'd3, 5'd11, 32'h0000_000B);

        // Gated cycle: outputs hold and the write to register 3 is dropped.
        step("gated", 1'b1, 1'b0, 5'd4, 5'd0, 5'd3, 32'hDEAD_BEEF);
        step("read_r3_after_gate", 1'b1, 1'b1, 5'd3, 5'd4, 5'd12, 32'h0000_000C);

        // Reset in the middle of operation clears a previously written register.
        step("load_r31", 1'b1, 1'b1, 5'd0, 5'd0, 5'd31, 32'hCAFE_F00D);
        step("mid_reset", 1'b0, 1'b1, 5'd31, 5'd31, 5'd31, 32'h5555_5555);
        step("read_r31", 1'b1, 1'b1, 5'd31, 5'd0, 5'd13, 32'h0000_000D);

        // Random traffic, biased toward collisions and occasional resets.
        for (int n = 0; n < 400; n++) begin
            a1 = 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            a3 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            step("random", ($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
                 a1, a2, a3, $urandom);
        end

        drain = 0;
        while (sb.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        #2;
        if (sb.size() > 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
